// File: rtl/binary_down_timer.sv
// Purpose : loadable down-counter with run/pause/done control, optional periodic reload.
// Latency : out/tc/busy/done are all registered; tc rises on the same edge out leaves 1.
// Backpres: none; tick is a count-enable strobe, start/pause/load are level-sampled each clk.
//
// Ports:
//   clk         - single clock, rising edge
//   rst         - asynchronous active-high reset
//   load        - capture load_val into count and reload register (highest priority)
//   load_val    - start/reload value
//   start       - run from IDLE, resume from PAUSE, restart from DONE
//   pause       - halt counting while in RUN
//   tick        - one decrement per clk while in RUN
//   auto_reload - 1: periodic (reload from rld at terminal count), 0: one-shot
//   out         - current count
//   tc          - one-cycle terminal-count pulse
//   busy        - 1 in RUN or PAUSE
//   done        - 1 in DONE
module binary_down_timer #(
  parameter int CNT_BIT_WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [CNT_BIT_WIDTH-1:0] load_val,
  input  logic                     start,
  input  logic                     pause,
  input  logic                     tick,
  input  logic                     auto_reload,
  output logic [CNT_BIT_WIDTH-1:0] out,
  output logic                     tc,
  output logic                     busy,
  output logic                     done
);

  localparam logic [CNT_BIT_WIDTH-1:0] CNT_ONE = CNT_BIT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                   state, state_nxt;
  logic [CNT_BIT_WIDTH-1:0] rld, rld_nxt;
  logic [CNT_BIT_WIDTH-1:0] out_nxt;
  logic                     tc_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      out   <= '0;
      rld   <= '0;
      tc    <= 1'b0;
    end else begin
      state <= state_nxt;
      out   <= out_nxt;
      rld   <= rld_nxt;
      tc    <= tc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    out_nxt   = out;
    rld_nxt   = rld;
    tc_nxt    = 1'b0;

    if (load) begin
      // load overrides everything else that cycle and parks the timer in IDLE
      out_nxt   = load_val;
      rld_nxt   = load_val;
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start && (out != '0)) state_nxt = ST_RUN;
        end

        ST_RUN: begin
          // pause wins over tick: no decrement on the cycle we stop
          if (pause) begin
            state_nxt = ST_PAUSE;
          end else if (tick) begin
            if (out > CNT_ONE) begin
              out_nxt = out - CNT_ONE;
            end else if (out == CNT_ONE) begin
              tc_nxt = 1'b1;
              if (auto_reload && (rld != '0)) begin
                out_nxt = rld;
              end else begin
                out_nxt   = '0;
                state_nxt = ST_DONE;
              end
            end else begin
              // a zero count in RUN is unreachable; settle into DONE rather than wrap
              state_nxt = ST_DONE;
            end
          end
        end

        ST_PAUSE: begin
          if (start && !pause) state_nxt = ST_RUN;
        end

        ST_DONE: begin
          if (start && (rld != '0)) begin
            out_nxt   = rld;
            state_nxt = ST_RUN;
          end
        end

        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_RUN) || (state == ST_PAUSE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_binary_down_timer.sv
// Bench for binary_down_timer: directed vector table, async-reset sequences,
// then randomized traffic compared against a behavioural model.
module tb_binary_down_timer;

  localparam int W = 9;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         start = 1'b0;
  logic         pause = 1'b0;
  logic         tick = 1'b0;
  logic         auto_reload = 1'b0;
  logic [W-1:0] out;
  logic         tc;
  logic         busy;
  logic         done;

  int checks = 0;
  int failures = 0;

  binary_down_timer #(.CNT_BIT_WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .load_val    (load_val),
    .start       (start),
    .pause       (pause),
    .tick        (tick),
    .auto_reload (auto_reload),
    .out         (out),
    .tc          (tc),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ld, lv, st, pa, tk, ar;
    int e_out, e_tc, e_busy, e_done;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input int idx,
                     input logic [W+2:0] act, input logic [W+2:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d]: got out=%0d tc=%0d busy=%0d done=%0d, want out=%0d tc=%0d busy=%0d done=%0d",
               nm, idx, act[W+2:3], act[2], act[1], act[0],
               exp[W+2:3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [W+2:0] pack(input int o, input int t, input int b, input int d);
    logic [W-1:0] ov;
    ov = W'(o);
    return {ov, t[0], b[0], d[0]};
  endfunction

  // drive one cycle's inputs, let the edge happen, sample 1 time unit later
  task automatic cyc(input int ld, input int lv, input int st, input int pa,
                     input int tk, input int ar);
    load = ld[0]; load_val = W'(lv); start = st[0]; pause = pa[0];
    tick = tk[0]; auto_reload = ar[0];
    @(posedge clk);
    #1;
  endtask

  task automatic add(input int ld, input int lv, input int st, input int pa, input int tk,
                     input int ar, input int eo, input int et, input int eb, input int ed);
    vec_t v;
    v = '{ld, lv, st, pa, tk, ar, eo, et, eb, ed};
    vecs.push_back(v);
  endtask

  // behavioural model, expressed as run/paused/finished flags and an integer count
  int m_cnt, m_rld;
  bit m_run, m_pau, m_fin, m_tc;

  task automatic model_reset();
    m_cnt = 0; m_rld = 0; m_run = 0; m_pau = 0; m_fin = 0; m_tc = 0;
  endtask

  task automatic model_step(input bit ld, input int lv, input bit st, input bit pa,
                            input bit tk, input bit ar);
    m_tc = 0;
    if (ld) begin
      m_cnt = lv; m_rld = lv; m_run = 0; m_pau = 0; m_fin = 0;
    end else if (m_run) begin
      if (pa) begin
        m_run = 0; m_pau = 1;
      end else if (tk) begin
        if (m_cnt == 1) begin
          m_tc = 1;
          if (ar && m_rld != 0) m_cnt = m_rld;
          else begin m_cnt = 0; m_run = 0; m_fin = 1; end
        end else begin
          m_cnt = (m_cnt + (1 << W) - 1) % (1 << W);
        end
      end
    end else if (m_pau) begin
      if (st && !pa) begin m_pau = 0; m_run = 1; end
    end else if (m_fin) begin
      if (st && m_rld != 0) begin m_cnt = m_rld; m_fin = 0; m_run = 1; end
    end else begin
      if (st && m_cnt != 0) m_run = 1;
    end
  endtask

  initial begin
    // ---------------- reset state, asserted with no clock edge in between
    #1 rst = 1'b1;
    #1;
    chk("reset_async", 0, {out, tc, busy, done}, pack(0, 0, 0, 0));
    @(posedge clk); #1;
    chk("reset_held", 0, {out, tc, busy, done}, pack(0, 0, 0, 0));
    rst = 1'b0;

    // ---------------- vector table: ld lv st pa tk ar | out tc busy done
    // one-shot from 3
    add(1, 3, 0, 0, 0, 0,   3, 0, 0, 0);
    add(0, 0, 1, 0, 1, 0,   3, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0,   2, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0,   1, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0,   0, 1, 0, 1);
    add(0, 0, 0, 0, 1, 0,   0, 0, 0, 1);
    add(0, 0, 0, 1, 1, 0,   0, 0, 0, 1);   // pause in DONE ignored
    // periodic from 2
    add(1, 2, 0, 0, 1, 1,   2, 0, 0, 0);
    add(0, 0, 1, 0, 1, 1,   2, 0, 1, 0);
    add(0, 0, 0, 0, 1, 1,   1, 0, 1, 0);
    add(0, 0, 0, 0, 1, 1,   2, 1, 1, 0);
    add(0, 0, 0, 0, 1, 1,   1, 0, 1, 0);
    add(0, 0, 0, 0, 1, 1,   2, 1, 1, 0);
    add(0, 0, 0, 0, 0, 1,   2, 0, 1, 0);   // no tick: hold
    add(0, 0, 1, 0, 1, 1,   1, 0, 1, 0);   // start in RUN ignored
    // pause / resume from 5
    add(1, 5, 0, 0, 0, 0,   5, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0,   5, 0, 0, 0);   // pause in IDLE ignored
    add(0, 0, 1, 0, 0, 0,   5, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0,   4, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0,   3, 0, 1, 0);
    add(0, 0, 0, 1, 1, 0,   3, 0, 1, 0);   // pause beats tick
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 1, 0, 3, 0, 1, 0);
    add(0, 0, 1, 1, 1, 0,   3, 0, 1, 0);   // start+pause stays paused
    add(0, 0, 0, 0, 1, 0,   3, 0, 1, 0);
    add(0, 0, 1, 0, 0, 0,   3, 0, 1, 0);   // resume
    add(0, 0, 0, 0, 1, 0,   2, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0,   1, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0,   0, 1, 0, 1);
    // full-scale start, load mid-run
    add(1, 511, 0, 0, 0, 0, 511, 0, 0, 0);
    add(0, 0, 1, 0, 1, 0,   511, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0,   510, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0,   509, 0, 1, 0);
    add(1, 7, 0, 0, 1, 0,   7, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0,   7, 0, 0, 0);   // tick in IDLE ignored
    add(1, 1, 1, 0, 1, 0,   1, 0, 0, 0);   // load beats start
    add(0, 0, 1, 0, 0, 0,   1, 0, 1, 0);
    add(1, 4, 0, 0, 1, 0,   4, 0, 0, 0);   // load at out==1 suppresses tc
    // zero load, DONE restart
    add(1, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    add(0, 0, 1, 0, 1, 0,   0, 0, 0, 0);   // start with out==0 ignored
    add(1, 1, 0, 0, 0, 0,   1, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0,   1, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0,   0, 1, 0, 1);
    add(0, 0, 1, 0, 0, 0,   1, 0, 1, 0);   // restart from rld
    add(0, 0, 0, 0, 1, 0,   0, 1, 0, 1);
    add(0, 0, 1, 0, 0, 0,   1, 0, 1, 0);
    add(0, 0, 0, 0, 1, 1,   1, 1, 1, 0);   // periodic with rld=1

    foreach (vecs[i]) begin
      cyc(vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].pa, vecs[i].tk, vecs[i].ar);
      chk("vec", i, {out, tc, busy, done},
          pack(vecs[i].e_out, vecs[i].e_tc, vecs[i].e_busy, vecs[i].e_done));
    end

    // ---------------- async reset mid-RUN at out=4
    cyc(1, 5, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("rst_pre", 0, {out, tc, busy, done}, pack(4, 0, 1, 0));
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_run", 0, {out, tc, busy, done}, pack(0, 0, 0, 0));
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(0, 0, 1, 0, 0, 0);
    chk("rst_then_start", 0, {out, tc, busy, done}, pack(0, 0, 0, 0));
    cyc(0, 0, 0, 0, 1, 0);
    chk("rst_then_tick", 0, {out, tc, busy, done}, pack(0, 0, 0, 0));

    // reset held across the edge where tc would have fired
    cyc(1, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    tick = 1'b1;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_blocks_tc", 0, {out, tc, busy, done}, pack(0, 0, 0, 0));
    rst = 1'b0;
    // first edge after release behaves normally: load is taken
    cyc(1, 2, 0, 0, 1, 0);
    chk("post_rst_load", 0, {out, tc, busy, done}, pack(2, 0, 0, 0));

    // ---------------- randomized traffic against the model
    rst = 1'b1;
    #1;
    rst = 1'b0;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      bit r_ld, r_st, r_pa, r_tk, r_ar;
      int r_lv;
      r_ld = ($urandom_range(0, 15) == 0);
      r_lv = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 5))
                                          : int'($urandom_range(0, (1 << W) - 1));
      r_st = ($urandom_range(0, 3) == 0);
      r_pa = ($urandom_range(0, 7) == 0);
      r_tk = ($urandom_range(0, 1) == 1);
      r_ar = ($urandom_range(0, 1) == 1);
      cyc(int'(r_ld), r_lv, int'(r_st), int'(r_pa), int'(r_tk), int'(r_ar));
      model_step(r_ld, r_lv, r_st, r_pa, r_tk, r_ar);
      chk("rand", n, {out, tc, busy, done},
          pack(m_cnt, int'(m_tc), int'(m_run | m_pau), int'(m_fin)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
